// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and RAM-side signals of the load/store controller.
// The controller uses the slave modport. The requester and RAM side use master.
interface lsu_mem_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;
    logic [WIDTH-1:0] ram_wr_data;
    logic [WIDTH-1:0] ram_rd_data;
    logic             ram_rd_en;
    logic             ram_wr_en;
    logic [WIDTH-1:0] ram_addr;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               ram_wr_data, ram_rd_en, ram_wr_en, ram_addr
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               ram_wr_data, ram_rd_en, ram_wr_en, ram_addr
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Byte/halfword/word load-store controller in front of a word-only RAM.
// Sub-word stores are performed as read-modify-write.
module lsu_mem_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    lsu_mem_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             we_q, we_d;
    logic             uns_q, uns_d;
    logic             err_q, err_d;
    logic [1:0]       size_q, size_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] buf_q, buf_d;

    logic             req_err;
    logic [WIDTH:0]   nbytes;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] load_val;
    logic [7:0]       lane8;
    logic [15:0]      lane16;

    // The range check uses one extra bit so that addr+size cannot wrap around.
    always_comb begin
        case (bus.req_size)
            2'b00:   nbytes = (WIDTH+1)'(1);
            2'b01:   nbytes = (WIDTH+1)'(2);
            default: nbytes = (WIDTH+1)'(4);
        endcase
        req_err = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
               || (({1'b0, bus.req_addr} + nbytes) > (WIDTH+1)'(MEM_BYTES));
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                we_d    = bus.req_we;
                uns_d   = bus.req_unsigned;
                size_d  = bus.req_size;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                err_d   = req_err;
                if (req_err)                               state_d = RESP;
                else if (bus.req_we && bus.req_size == 2'b10) state_d = WRITE;
                else                                       state_d = READ;
            end
            READ:  state_d = WAIT;
            WAIT: begin
                buf_d   = bus.ram_rd_data;
                state_d = we_q ? WRITE : RESP;
            end
            WRITE: state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
        end
    end

    // Little-endian lane select shared by the merge and the load path.
    assign lane8  = buf_q[{addr_q[1:0], 3'b000} +: 8];
    assign lane16 = buf_q[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        merged = buf_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   load_val = uns_q ? {{(WIDTH-8){1'b0}}, lane8}
                                      : {{(WIDTH-8){lane8[7]}}, lane8};
            2'b01:   load_val = uns_q ? {{(WIDTH-16){1'b0}}, lane16}
                                      : {{(WIDTH-16){lane16[15]}}, lane16};
            default: load_val = buf_q;
        endcase
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.ram_rd_en   = (state_q == READ);
    assign bus.ram_wr_en   = (state_q == WRITE);
    assign bus.ram_addr    = (state_q == READ || state_q == WRITE) ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign bus.ram_wr_data = (state_q == WRITE) ? merged : '0;
    assign bus.resp_valid  = (state_q == RESP);
    assign bus.resp_err    = (state_q == RESP) && err_q;
    assign bus.resp_rdata  = (state_q == RESP && !err_q && !we_q) ? load_val : '0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a byte-array memory model.
// The bench also includes a word RAM that models the real array.
module tb_lsu_mem_ctrl;
    localparam int WIDTH     = 32;
    localparam int MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.WIDTH(WIDTH)) bus ();
    lsu_mem_ctrl #(.WIDTH(WIDTH), .MEM_BYTES(MEM_BYTES)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] ram  [MEM_BYTES/4] = '{default: '0};
    logic [7:0]  rmem [MEM_BYTES]   = '{default: '0};
    int n_chk = 0;
    int n_err = 0;

    always @(posedge clk) begin
        if (bus.ram_wr_en) ram[bus.ram_addr[9:2]] <= bus.ram_wr_data;
        if (bus.ram_rd_en) bus.ram_rd_data <= ram[bus.ram_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
    endfunction

    // One request through the DUT. Expectations come from the byte-level memory model.
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int n, exp_lat, exp_rd, exp_wr, rdc, wrc, cyc;
        bit err, got;
        logic [31:0] v, exp_data;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
           || (longint'(a) + n > MEM_BYTES);
        exp_data = '0;
        if (err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[a + i];
            if (n == 1)      exp_data = uns ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            else if (n == 2) exp_data = uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else             exp_data = v;
        end else begin
            exp_lat = (n == 4) ? 2 : 4; exp_rd = (n == 4) ? 0 : 1; exp_wr = 1;
            for (int i = 0; i < n; i++) rmem[a + i] = wd[8*i +: 8];
        end

        chk("ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        bus.req_size = 2'($urandom); bus.req_we = 1'($urandom);
        cyc = 1; rdc = 0; wrc = 0; got = 0;
        while (cyc <= 8) begin
            if (bus.ram_rd_en) rdc++;
            if (bus.ram_wr_en) wrc++;
            if (bus.ram_rd_en || bus.ram_wr_en) begin
                chk("ram_addr", bus.ram_addr, {a[31:2], 2'b00});
                chk("rd_wr_excl", bus.ram_rd_en && bus.ram_wr_en, 1'b0);
            end
            if (bus.resp_valid) begin
                got = 1;
                break;
            end
            chk("busy_ready", bus.req_ready, 1'b0);
            @(posedge clk); #1;
            cyc++;
        end
        bus.req_valid = 1'b0;
        chk("resp_seen", got, 1'b1);
        chk("latency", cyc, exp_lat);
        chk("resp_err", bus.resp_err, err);
        chk("resp_rdata", bus.resp_rdata, exp_data);
        chk("rd_pulses", rdc, exp_rd);
        chk("wr_pulses", wrc, exp_wr);
        @(posedge clk); #1;
        chk("resp_single", bus.resp_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] a, snap;
        logic [1:0]  sz;
        int          nb;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_resp", {bus.resp_valid, bus.resp_err, bus.ram_rd_en, bus.ram_wr_en}, 4'b0);
        chk("rst_addr", bus.ram_addr, 32'h0);
        chk("rst_wdata", bus.ram_wr_data, 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store and load back.
        txn(1, 2'd2, 0, 32'h010, 32'hDEADBEEF, 0);
        txn(0, 2'd2, 0, 32'h010, 32'h0, 0);
        chk("word_ram", ram[4], 32'hDEADBEEF);
        // Byte read-modify-write.
        txn(1, 2'd2, 0, 32'h020, 32'h11223344, 0);
        txn(1, 2'd0, 0, 32'h022, 32'h000000AA, 0);
        chk("byte_rmw_ram", ram[8], 32'h11AA3344);
        txn(0, 2'd0, 0, 32'h022, 32'h0, 1);
        txn(0, 2'd0, 1, 32'h022, 32'h0, 0);
        // Halfword path.
        txn(1, 2'd1, 0, 32'h032, 32'h00008001, 0);
        chk("half_rmw_ram", ram[12], 32'h80010000);
        txn(0, 2'd1, 0, 32'h032, 32'h0, 1);
        txn(0, 2'd1, 1, 32'h032, 32'h0, 0);
        // Misaligned, illegal-size and out-of-range requests.
        txn(0, 2'd2, 0, 32'h006, 32'h0, 0);
        txn(1, 2'd1, 0, 32'h011, 32'h1234, 0);
        txn(0, 2'd3, 0, 32'h040, 32'h0, 1);
        txn(0, 2'd2, 0, 32'h3FE, 32'h0, 0);
        txn(0, 2'd2, 0, 32'h400, 32'h0, 0);
        txn(1, 2'd2, 0, 32'h3FC, 32'hCAFEF00D, 0);
        txn(0, 2'd2, 0, 32'h3FC, 32'h0, 0);

        // Apply reset while a byte store is in WAIT. The RAM word must stay unchanged.
        snap = ram[8];
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h021; bus.req_wdata = 32'h55;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_ready", bus.req_ready, 1'b1);
        chk("rstmid_outs", {bus.resp_valid, bus.resp_err, bus.ram_rd_en, bus.ram_wr_en}, 4'b0);
        chk("rstmid_addr", bus.ram_addr, 32'h0);
        chk("rstmid_rdata", bus.resp_rdata, 32'h0);
        @(posedge clk); #1;
        chk("rstmid_ram", ram[8], snap);
        chk("rstmid_ram_ref", ram[8], ref_word(32'h020));

        for (int t = 0; t < 300; t++) begin
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
            nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            a  = $urandom_range(0, MEM_BYTES + 3);
            if ($urandom_range(0, 3) != 0) a = a & ~(nb - 1);
            txn(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom));
        end

        for (int w = 0; w < MEM_BYTES/4; w++) chk("final_ram", ram[w], ref_word(w*4));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
